wb_commit_unit: RTL and testbench

- Writeback-side consumer of the X__W protocol. It sits downstream of the per-pipe execute queues and commits their results in program order.
- Each input pipe presents pc/seq_num/waddr/wdata/wen with val/rdy.
- The block accepts only the message whose seq_num equals the next expected sequence number. It drives one registered register-file write port and a commit notification to the front end.

---
 rtl/wb_commit_unit.sv | 154 +++++++++++++++
 tb/tb_wb_commit_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: in-order writeback commit stage for the X__W protocol.
//
// Several execute pipes present results (pc/seq_num/waddr/wdata/wen) with val/rdy. Only
// the message whose seq_num equals the expected sequence number is accepted. On acceptance
// the block drives one registered register-file write port and a registered commit
// notification, each a one-cycle pulse.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_val/in_rdy       per-pipe handshake (in_rdy is one-hot or zero)
//   in_pc, in_seq_num, in_waddr, in_wdata, in_wen   per-pipe message fields, packed by pipe
//   rf_wen/rf_waddr/rf_wdata                         registered register-file write
//   commit_val/commit_pc/commit_seq_num              registered commit notification
//   stall_cycles        (only with WB_COMMIT_STALL_CNT_EN) saturating count of cycles with
//                       valid input but no pipe holding the expected seq_num
//
// Optional feature macro: WB_COMMIT_STALL_CNT_EN

module wb_commit_unit #(
   parameter int unsigned p_num_pipes    = 2,
   parameter int unsigned p_seq_num_bits = 5
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [p_num_pipes-1:0]                in_val,
   output logic [p_num_pipes-1:0]                in_rdy,
   input  logic [p_num_pipes*32-1:0]             in_pc,
   input  logic [p_num_pipes*p_seq_num_bits-1:0] in_seq_num,
   input  logic [p_num_pipes*5-1:0]              in_waddr,
   input  logic [p_num_pipes*32-1:0]             in_wdata,
   input  logic [p_num_pipes-1:0]                in_wen,
`ifdef WB_COMMIT_STALL_CNT_EN
   output logic [15:0]                           stall_cycles,
`endif
   output logic                                  rf_wen,
   output logic [4:0]                            rf_waddr,
   output logic [31:0]                           rf_wdata,
   output logic                                  commit_val,
   output logic [31:0]                           commit_pc,
   output logic [p_seq_num_bits-1:0]             commit_seq_num
);

   logic [p_seq_num_bits-1:0] exp_seq_q, exp_seq_d;
   logic                      rf_wen_q, rf_wen_d;
   logic [4:0]                rf_waddr_q, rf_waddr_d;
   logic [31:0]               rf_wdata_q, rf_wdata_d;
   logic                      commit_val_q, commit_val_d;
   logic [31:0]               commit_pc_q, commit_pc_d;
   logic [p_seq_num_bits-1:0] commit_seq_q, commit_seq_d;

   logic [p_num_pipes-1:0]    grant;
   logic                      any_match;
   logic                      accept;
   logic [31:0]               win_pc;
   logic [p_seq_num_bits-1:0] win_seq;
   logic [4:0]                win_waddr;
   logic [31:0]               win_wdata;
   logic                      win_wen;

   // Priority select: lowest-index pipe holding the expected seq_num wins.
   always_comb begin
      grant     = '0;
      any_match = 1'b0;
      win_pc    = '0;
      win_seq   = '0;
      win_waddr = '0;
      win_wdata = '0;
      win_wen   = 1'b0;
      for (int i = 0; i < p_num_pipes; i++) begin
         if (in_val[i] && (in_seq_num[i*p_seq_num_bits +: p_seq_num_bits] == exp_seq_q)
             && !any_match) begin
            any_match = 1'b1;
            grant[i]  = 1'b1;
            win_pc    = in_pc[i*32 +: 32];
            win_seq   = in_seq_num[i*p_seq_num_bits +: p_seq_num_bits];
            win_waddr = in_waddr[i*5 +: 5];
            win_wdata = in_wdata[i*32 +: 32];
            win_wen   = in_wen[i];
         end
      end
   end

   // Ready is withheld during reset so nothing in flight is accepted.
   assign in_rdy = rst ? '0 : grant;
   assign accept = any_match && !rst;

   always_comb begin
      exp_seq_d    = exp_seq_q;
      rf_wen_d     = 1'b0;
      rf_waddr_d   = rf_waddr_q;
      rf_wdata_d   = rf_wdata_q;
      commit_val_d = 1'b0;
      commit_pc_d  = commit_pc_q;
      commit_seq_d = commit_seq_q;
      if (accept) begin
         exp_seq_d    = exp_seq_q + p_seq_num_bits'(1);  // wraps naturally
         rf_wen_d     = win_wen && (win_waddr != 5'd0);  // x0 is never written
         rf_waddr_d   = win_waddr;
         rf_wdata_d   = win_wdata;
         commit_val_d = 1'b1;
         commit_pc_d  = win_pc;
         commit_seq_d = win_seq;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_seq_q    <= '0;
         rf_wen_q     <= 1'b0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         commit_val_q <= 1'b0;
         commit_pc_q  <= '0;
         commit_seq_q <= '0;
      end else begin
         exp_seq_q    <= exp_seq_d;
         rf_wen_q     <= rf_wen_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_wdata_q   <= rf_wdata_d;
         commit_val_q <= commit_val_d;
         commit_pc_q  <= commit_pc_d;
         commit_seq_q <= commit_seq_d;
      end
   end

   assign rf_wen         = rf_wen_q;
   assign rf_waddr       = rf_waddr_q;
   assign rf_wdata       = rf_wdata_q;
   assign commit_val     = commit_val_q;
   assign commit_pc      = commit_pc_q;
   assign commit_seq_num = commit_seq_q;

`ifdef WB_COMMIT_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((|in_val) && !any_match && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit (2 pipes, 3-bit seq_num so wrap is exercised).
module tb_wb_commit_unit;

   localparam int unsigned NP = 2;
   localparam int unsigned SB = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     in_val = '0;
   logic [NP-1:0]     in_rdy;
   logic [NP*32-1:0]  in_pc = '0;
   logic [NP*SB-1:0]  in_seq_num = '0;
   logic [NP*5-1:0]   in_waddr = '0;
   logic [NP*32-1:0]  in_wdata = '0;
   logic [NP-1:0]     in_wen = '0;
   logic              rf_wen;
   logic [4:0]        rf_waddr;
   logic [31:0]       rf_wdata;
   logic              commit_val;
   logic [31:0]       commit_pc;
   logic [SB-1:0]     commit_seq_num;
`ifdef WB_COMMIT_STALL_CNT_EN
   logic [15:0]       stall_cycles;
`endif

   wb_commit_unit #(.p_num_pipes(NP), .p_seq_num_bits(SB)) dut (
      .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_pc(in_pc),
      .in_seq_num(in_seq_num), .in_waddr(in_waddr), .in_wdata(in_wdata), .in_wen(in_wen),
`ifdef WB_COMMIT_STALL_CNT_EN
      .stall_cycles(stall_cycles),
`endif
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .commit_val(commit_val),
      .commit_pc(commit_pc), .commit_seq_num(commit_seq_num)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [SB-1:0] seq;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        wen;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [SB-1:0] m_exp = '0;
   int          m_stall = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_pipe(input int p, input logic v, input logic [31:0] pc,
                           input logic [SB-1:0] seq, input logic [4:0] wa,
                           input logic [31:0] wd, input logic we);
      in_val[p]              = v;
      in_pc[p*32 +: 32]      = pc;
      in_seq_num[p*SB +: SB] = seq;
      in_waddr[p*5 +: 5]     = wa;
      in_wdata[p*32 +: 32]   = wd;
      in_wen[p]              = we;
   endtask

   // One clock: model the grant, check in_rdy, push expectation, clock, check outputs.
   task automatic cycle(input string tag);
      int   win;
      logic [NP-1:0] exp_rdy;
      exp_t e;
      win = -1;
      exp_rdy = '0;
      for (int i = NP - 1; i >= 0; i--) begin
         if (in_val[i] && in_seq_num[i*SB +: SB] == m_exp) win = i;
      end
      if (win >= 0) begin
         exp_rdy[win] = 1'b1;
         e.pc    = in_pc[win*32 +: 32];
         e.seq   = in_seq_num[win*SB +: SB];
         e.waddr = in_waddr[win*5 +: 5];
         e.wdata = in_wdata[win*32 +: 32];
         e.wen   = in_wen[win];
         sb_q.push_back(e);
         m_exp = m_exp + 1'b1;
      end else if (|in_val) begin
         if (m_stall < 16'hFFFF) m_stall++;
      end
      #1;
      check({tag, ".in_rdy"}, 32'(in_rdy), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, ".commit_val"}, 32'(commit_val), 32'd1);
         check({tag, ".commit_pc"}, commit_pc, e.pc);
         check({tag, ".commit_seq"}, 32'(commit_seq_num), 32'(e.seq));
         check({tag, ".rf_wen"}, 32'(rf_wen), 32'(e.wen && e.waddr != 5'd0));
         check({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(e.waddr));
         check({tag, ".rf_wdata"}, rf_wdata, e.wdata);
      end else begin
         check({tag, ".commit_val_idle"}, 32'(commit_val), 32'd0);
         check({tag, ".rf_wen_idle"}, 32'(rf_wen), 32'd0);
      end
   endtask

   task automatic clear_inputs();
      in_val = '0;
      in_wen = '0;
   endtask

   initial begin
      // Reset state, with a valid matching message present.
      set_pipe(0, 1'b1, 32'h100, 3'd0, 5'd1, 32'h1, 1'b1);
      @(posedge clk);
      #1;
      check("rst.in_rdy", 32'(in_rdy), 32'd0);
      check("rst.commit_val", 32'(commit_val), 32'd0);
      check("rst.rf_wen", 32'(rf_wen), 32'd0);
      check("rst.rf_wdata", rf_wdata, 32'd0);
      clear_inputs();
      rst = 1'b0;

      // Single message.
      set_pipe(0, 1'b1, 32'h200, 3'd0, 5'd5, 32'hDEAD, 1'b1);
      cycle("single");
      clear_inputs();
      cycle("idle");

      // Out-of-order arrival: pipe1 holds seq=2 before seq=1 shows up on pipe0.
      set_pipe(1, 1'b1, 32'h300, 3'd2, 5'd7, 32'hBEEF, 1'b1);
      cycle("ooo.stall");
      set_pipe(0, 1'b1, 32'h2FC, 3'd1, 5'd6, 32'hCAFE, 1'b1);
      cycle("ooo.first");
      in_val[0] = 1'b0;
      cycle("ooo.second");
      clear_inputs();

      // x0 write and wen=0.
      set_pipe(0, 1'b1, 32'h400, 3'd3, 5'd0, 32'h1111, 1'b1);
      cycle("x0");
      set_pipe(0, 1'b1, 32'h404, 3'd4, 5'd3, 32'h2222, 1'b0);
      cycle("wen0");
      clear_inputs();

      // Duplicate seq: pipe0 wins, pipe1 then stalls.
      set_pipe(0, 1'b1, 32'h500, 3'd5, 5'd8, 32'h5050, 1'b1);
      set_pipe(1, 1'b1, 32'h600, 3'd5, 5'd9, 32'h6060, 1'b1);
      cycle("dup.win");
      in_val[0] = 1'b0;
      cycle("dup.stall");
      clear_inputs();

      // Wrap-around: 10 back-to-back commits alternating pipes.
      for (int k = 0; k < 10; k++) begin
         clear_inputs();
         set_pipe(k % 2, 1'b1, 32'h1000 + 32'(k * 4), m_exp, 5'(k + 1),
                  $urandom, 1'b1);
         cycle($sformatf("wrap%0d", k));
      end
      clear_inputs();
      check("wrap.model_exp", 32'(m_exp), 32'd0);

      // Reset mid-stream after three commits.
      for (int k = 0; k < 3; k++) begin
         set_pipe(0, 1'b1, 32'h2000 + 32'(k * 4), m_exp, 5'd10, 32'(k + 32'hA0), 1'b1);
         cycle($sformatf("pre_rst%0d", k));
      end
      set_pipe(0, 1'b1, 32'h200C, 3'd3, 5'd11, 32'hA3, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst.commit_val", 32'(commit_val), 32'd0);
      check("mid_rst.rf_wen", 32'(rf_wen), 32'd0);
      check("mid_rst.rf_waddr", 32'(rf_waddr), 32'd0);
      check("mid_rst.commit_pc", commit_pc, 32'd0);
      check("mid_rst.in_rdy", 32'(in_rdy), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_exp = '0;
      m_stall = 0;
      sb_q.delete();
      cycle("post_rst.stall");
      set_pipe(0, 1'b1, 32'h3000, 3'd0, 5'd12, 32'h3333, 1'b1);
      cycle("post_rst.commit");
      clear_inputs();
      cycle("post_rst.idle");

`ifdef WB_COMMIT_STALL_CNT_EN
      check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
